lsu_agen: RTL and testbench
===========================

LSU_AGEN -- requirements
Module: lsu_agen

Interface
REQ-001 SHALL have port: clk  in  1  system clock; every register updates on its rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: i_ld_st_add_op  in  1  command strobe from the fetch/execute stage, one cycle per command.
REQ-004 SHALL have port: i_rd1  in  16  load base address.
REQ-005 SHALL have port: i_func  in  4  load word count, 0..15; 0 means no load.
REQ-006 SHALL have port: i_rd1_st  in  16  store base address.
REQ-007 SHALL have port: i_func_st  in  4  store word count, 0..15; 0 means no store.
REQ-008 SHALL have port: i_delay  in  4  load-to-store latency in cycles.
REQ-009 SHALL have port: i_first_set  in  1  synchronous abort and clear.
REQ-010 SHALL have port: o_ld_re  out  1  load read enable to the data memory.
REQ-011 SHALL have port: o_ld_addr  out  16  load address.
REQ-012 SHALL have port: o_st_we  out  1  store write enable to the data memory.
REQ-013 SHALL have port: o_st_addr  out  16  store address.
REQ-014 SHALL have port: o_busy  out  1  high while either side is not idle.
REQ-015 SHALL have port: o_err  out  1  sticky flag: a command was dropped.
REQ-016 SHALL drive all outputs directly from registers (no combinational paths from inputs to outputs).

Function
REQ-017 SHALL sample a command at edge T when i_ld_st_add_op=1, o_busy=0 and i_first_set=0. At that edge it latches the base addresses, both counts and the delay.
REQ-018 SHALL implement a load FSM with states L_IDLE and L_ACT. On accept: go to L_ACT if count>0, otherwise stay in L_IDLE.
REQ-019 In L_ACT, SHALL assert o_ld_re in cycles T+1 .. T+count. o_ld_addr = base+k in the k-th of those cycles, k counting from 0. Then return to L_IDLE.
REQ-020 SHALL implement a store FSM with states S_IDLE, S_WAIT and S_ACT. On accept:
- store count 0 -> stay in S_IDLE;
- store count >0 and delay 0 -> go to S_ACT;
- store count >0 and delay >0 -> go to S_WAIT.
REQ-021 S_WAIT SHALL last exactly delay cycles, then go to S_ACT. o_st_we is therefore asserted in cycles T+1+delay .. T+delay+store count, with o_st_addr = store base+k.
REQ-022 SHALL use delay 15 when a command arrives after reset and before any non-default delay has been latched. Each command latches i_delay at accept, exactly as presented.
REQ-023 SHALL compute addresses modulo 2^16: 0xFFFF+1 wraps to 0x0000 with no flag.
REQ-024 SHALL hold o_ld_addr and o_st_addr at their last driven value while the matching enable is 0.
REQ-025 SHALL drive o_busy = (load FSM != L_IDLE) OR (store FSM != S_IDLE), registered. A command with both counts 0 leaves o_busy=0.
REQ-026 SHALL drop a command seen while o_busy=1, including in the last active cycle. It then sets o_err=1 from the next cycle, and in-flight activity is unaffected.
REQ-027 On i_first_set=1, SHALL at the next edge:
- force both FSMs to idle;
- deassert o_ld_re and o_st_we;
- clear o_err.
This takes priority over a command in the same cycle, which is discarded and does not set o_err.
REQ-028 The load and store sides SHALL run concurrently, so o_ld_re and o_st_we may be high in the same cycle.

Reset
REQ-029 While rst_n=0, SHALL hold:
- o_ld_re=0, o_st_we=0, o_busy=0, o_err=0;
- o_ld_addr=0x0000, o_st_addr=0x0000;
- latched delay=15;
- both FSMs idle.
REQ-030 Asserting rst_n mid-operation SHALL abort immediately (asynchronously). The first command is accepted on the first edge after deassertion.

Verification
REQ-031 Load only: ld base 0x0100, count 3, store count 0 -> o_ld_re high T+1..T+3 with addresses 0x0100/0x0101/0x0102; o_st_we never high; o_busy low from T+4.
REQ-032 Load and store, delay 2: ld 0x0010 count 2, st 0x0200 count 2 -> o_st_we high T+3..T+4 at 0x0200/0x0201; o_busy low from T+5.
REQ-033 Wrap: ld base 0xFFFE, count 3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-034 Overlap: second command at T+2 while busy -> no effect on the sequence; o_err=1 from T+3; i_first_set pulse -> o_err=0 and o_busy=0 next cycle.
REQ-035 Mid-store reset: rst_n low during S_ACT -> all outputs reach their reset values immediately; after release, a new command with count 1 gives o_ld_re at T+1.
REQ-036 Zero counts and default delay: both counts 0 -> o_busy stays 0; after reset, store count 1 with i_delay=15 -> o_st_we at T+16.

Source files
------------

// File: rtl/lsu_agen.sv
// Load/store address generator: one command spawns a load burst and a
// delayed store burst, each walking consecutive word addresses.
module lsu_agen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ld_st_add_op,
  input  logic [15:0] i_rd1,
  input  logic [3:0]  i_func,
  input  logic [15:0] i_rd1_st,
  input  logic [3:0]  i_func_st,
  input  logic [3:0]  i_delay,
  input  logic        i_first_set,
  output logic        o_ld_re,
  output logic [15:0] o_ld_addr,
  output logic        o_st_we,
  output logic [15:0] o_st_addr,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic {
    L_IDLE,
    L_ACT
  } l_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACT
  } s_state_t;

  l_state_t    l_q, l_d;
  s_state_t    s_q, s_d;
  logic [3:0]  l_cnt_q, l_cnt_d;
  logic [3:0]  s_cnt_q, s_cnt_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic [3:0]  dly_q, dly_d;
  logic [15:0] st_base_q, st_base_d;
  logic        ld_re_d, st_we_d;
  logic [15:0] ld_addr_d, st_addr_d;
  logic        busy_d, err_d;
  logic        accept;

  assign accept = i_ld_st_add_op & ~o_busy & ~i_first_set;

  always_comb begin
    l_d       = l_q;
    s_d       = s_q;
    l_cnt_d   = l_cnt_q;
    s_cnt_d   = s_cnt_q;
    w_cnt_d   = w_cnt_q;
    dly_d     = dly_q;
    st_base_d = st_base_q;
    ld_re_d   = o_ld_re;
    st_we_d   = o_st_we;
    ld_addr_d = o_ld_addr;
    st_addr_d = o_st_addr;
    err_d     = o_err;

    if (i_first_set) begin
      l_d     = L_IDLE;
      s_d     = S_IDLE;
      ld_re_d = 1'b0;
      st_we_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (i_ld_st_add_op && o_busy)
        err_d = 1'b1;

      // busy is low only when both sides are idle, so accept
      // can only fire from the idle states
      if (accept) begin
        dly_d     = i_delay;
        st_base_d = i_rd1_st;
        l_cnt_d   = i_func - 4'd1;
        s_cnt_d   = i_func_st - 4'd1;
        w_cnt_d   = 4'd0;
      end

      unique case (l_q)
        L_IDLE: begin
          if (accept && i_func != 4'd0) begin
            l_d       = L_ACT;
            ld_re_d   = 1'b1;
            ld_addr_d = i_rd1;
          end
        end
        L_ACT: begin
          if (l_cnt_q == 4'd0) begin
            l_d     = L_IDLE;
            ld_re_d = 1'b0;
          end else begin
            ld_addr_d = o_ld_addr + 16'd1;
            l_cnt_d   = l_cnt_q - 4'd1;
          end
        end
        default: l_d = L_IDLE;
      endcase

      unique case (s_q)
        S_IDLE: begin
          if (accept && i_func_st != 4'd0) begin
            if (i_delay == 4'd0) begin
              s_d       = S_ACT;
              st_we_d   = 1'b1;
              st_addr_d = i_rd1_st;
            end else begin
              s_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_cnt_q == dly_q - 4'd1) begin
            s_d       = S_ACT;
            st_we_d   = 1'b1;
            st_addr_d = st_base_q;
          end else begin
            w_cnt_d = w_cnt_q + 4'd1;
          end
        end
        S_ACT: begin
          if (s_cnt_q == 4'd0) begin
            s_d     = S_IDLE;
            st_we_d = 1'b0;
          end else begin
            st_addr_d = o_st_addr + 16'd1;
            s_cnt_d   = s_cnt_q - 4'd1;
          end
        end
        default: s_d = S_IDLE;
      endcase
    end

    busy_d = (l_d != L_IDLE) || (s_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q       <= L_IDLE;
      s_q       <= S_IDLE;
      l_cnt_q   <= 4'd0;
      s_cnt_q   <= 4'd0;
      w_cnt_q   <= 4'd0;
      dly_q     <= 4'd15;
      st_base_q <= 16'h0000;
      o_ld_re   <= 1'b0;
      o_st_we   <= 1'b0;
      o_ld_addr <= 16'h0000;
      o_st_addr <= 16'h0000;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      l_q       <= l_d;
      s_q       <= s_d;
      l_cnt_q   <= l_cnt_d;
      s_cnt_q   <= s_cnt_d;
      w_cnt_q   <= w_cnt_d;
      dly_q     <= dly_d;
      st_base_q <= st_base_d;
      o_ld_re   <= ld_re_d;
      o_st_we   <= st_we_d;
      o_ld_addr <= ld_addr_d;
      o_st_addr <= st_addr_d;
      o_busy    <= busy_d;
      o_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_agen.sv
// Bench for lsu_agen: directed literal cases plus random traffic
// compared every cycle against a burst-window model.
module tb_lsu_agen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op = 1'b0;
  logic [15:0] rd1 = '0;
  logic [3:0]  func = '0;
  logic [15:0] rd1_st = '0;
  logic [3:0]  func_st = '0;
  logic [3:0]  dly = '0;
  logic        first_set = 1'b0;
  logic        ld_re, st_we, busy, err;
  logic [15:0] ld_addr, st_addr;

  int checks = 0;
  int errors = 0;

  lsu_agen dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_ld_st_add_op(op),
    .i_rd1(rd1),
    .i_func(func),
    .i_rd1_st(rd1_st),
    .i_func_st(func_st),
    .i_delay(dly),
    .i_first_set(first_set),
    .o_ld_re(ld_re),
    .o_ld_addr(ld_addr),
    .o_st_we(st_we),
    .o_st_addr(st_addr),
    .o_busy(busy),
    .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a command accepted at edge a makes loads active after edges
  // a..a+lc-1 and stores after edges a+d..a+d+sc-1.
  int          x = 0;
  int          acc = 0;
  int          m_lc = 0, m_sc = 0, m_d = 0;
  logic [15:0] m_lb = '0, m_sb = '0;
  logic [15:0] m_la = '0, m_sa = '0;
  logic        m_re = 0, m_we = 0, m_busy = 0, m_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_lc = 0; m_sc = 0;
        m_re = 0; m_we = 0; m_busy = 0; m_err = 0;
        m_la = '0; m_sa = '0;
      end
      chk("cyc_ld_re", {15'd0, ld_re}, {15'd0, m_re});
      chk("cyc_ld_addr", ld_addr, m_la);
      chk("cyc_st_we", {15'd0, st_we}, {15'd0, m_we});
      chk("cyc_st_addr", st_addr, m_sa);
      chk("cyc_busy", {15'd0, busy}, {15'd0, m_busy});
      chk("cyc_err", {15'd0, err}, {15'd0, m_err});
      if (rst_n) begin
        x++;
        if (first_set) begin
          m_lc = 0; m_sc = 0; m_err = 0;
        end else if (op) begin
          if (m_busy) m_err = 1;
          else begin
            acc = x;
            m_lb = rd1; m_lc = int'(func);
            m_sb = rd1_st; m_sc = int'(func_st);
            m_d = int'(dly);
          end
        end
        m_re = (m_lc > 0) && (x >= acc) && (x < acc + m_lc);
        if (m_re) m_la = m_lb + 16'(x - acc);
        m_we = (m_sc > 0) && (x >= acc + m_d) && (x < acc + m_d + m_sc);
        if (m_we) m_sa = m_sb + 16'(x - acc - m_d);
        m_busy = m_re || ((m_sc > 0) && (x >= acc) && (x < acc + m_d + m_sc));
      end
    end
  end

  task automatic drive(input logic [15:0] lb, input logic [3:0] lc,
                       input logic [15:0] sb, input logic [3:0] sc,
                       input logic [3:0] d);
    op = 1'b1; rd1 = lb; func = lc; rd1_st = sb; func_st = sc; dly = d;
  endtask

  task automatic issue(input logic [15:0] lb, input logic [3:0] lc,
                       input logic [15:0] sb, input logic [3:0] sc,
                       input logic [3:0] d);
    drive(lb, lc, sb, sc, d);
    @(posedge clk); #1;
    op = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic re, input logic [15:0] la,
                     input logic we, input logic [15:0] sa, input logic b);
    chk({name, "_re"}, {15'd0, ld_re}, {15'd0, re});
    if (re) chk({name, "_la"}, ld_addr, la);
    chk({name, "_we"}, {15'd0, st_we}, {15'd0, we});
    if (we) chk({name, "_sa"}, st_addr, sa);
    chk({name, "_busy"}, {15'd0, busy}, {15'd0, b});
  endtask

  initial begin
    step(3);
    pin("reset", 0, 16'h0, 0, 16'h0, 0);
    chk("reset_la", ld_addr, 16'h0000);
    chk("reset_err", {15'd0, err}, 16'd0);
    rst_n = 1'b1;
    step(1);

    // default delay 15 straight after reset
    issue(16'h0000, 4'd0, 16'h0300, 4'd1, 4'd15);
    step(14);
    pin("dly15_t15", 0, 16'h0, 0, 16'h0, 1);
    step(1);
    pin("dly15_t16", 0, 16'h0, 1, 16'h0300, 1);
    step(1);
    pin("dly15_t17", 0, 16'h0, 0, 16'h0, 0);
    chk("dly15_hold", st_addr, 16'h0300);

    // load only
    issue(16'h0100, 4'd3, 16'h0000, 4'd0, 4'd0);
    pin("ld_t1", 1, 16'h0100, 0, 16'h0, 1);
    step(1); pin("ld_t2", 1, 16'h0101, 0, 16'h0, 1);
    step(1); pin("ld_t3", 1, 16'h0102, 0, 16'h0, 1);
    step(1); pin("ld_t4", 0, 16'h0, 0, 16'h0, 0);

    // load + store with delay 2
    issue(16'h0010, 4'd2, 16'h0200, 4'd2, 4'd2);
    pin("ls_t1", 1, 16'h0010, 0, 16'h0, 1);
    step(1); pin("ls_t2", 1, 16'h0011, 0, 16'h0, 1);
    step(1); pin("ls_t3", 0, 16'h0, 1, 16'h0200, 1);
    step(1); pin("ls_t4", 0, 16'h0, 1, 16'h0201, 1);
    step(1); pin("ls_t5", 0, 16'h0, 0, 16'h0, 0);

    // address wrap
    issue(16'hFFFE, 4'd3, 16'h0000, 4'd0, 4'd0);
    pin("wrap_t1", 1, 16'hFFFE, 0, 16'h0, 1);
    step(1); pin("wrap_t2", 1, 16'hFFFF, 0, 16'h0, 1);
    step(1); pin("wrap_t3", 1, 16'h0000, 0, 16'h0, 1);
    step(1);

    // overlap sets err; first_set with a command clears it
    issue(16'h0040, 4'd4, 16'h0000, 4'd0, 4'd0);
    step(1);
    drive(16'h0900, 4'd2, 16'h0900, 4'd2, 4'd0);
    step(1);
    op = 1'b0;
    pin("ovl_t3", 1, 16'h0042, 0, 16'h0, 1);
    chk("ovl_err", {15'd0, err}, 16'd1);
    first_set = 1'b1;
    drive(16'h0A00, 4'd2, 16'h0000, 4'd0, 4'd0);
    step(1);
    op = 1'b0; first_set = 1'b0;
    pin("clr", 0, 16'h0, 0, 16'h0, 0);
    chk("clr_err", {15'd0, err}, 16'd0);
    step(2);
    pin("clr_drop", 0, 16'h0, 0, 16'h0, 0);

    // async reset in the middle of a store burst
    issue(16'h0000, 4'd0, 16'h0500, 4'd3, 4'd0);
    step(1);
    pin("mid_pre", 0, 16'h0, 1, 16'h0501, 1);
    rst_n = 1'b0;
    #1;
    pin("mid_rst", 0, 16'h0, 0, 16'h0, 0);
    chk("mid_rst_sa", st_addr, 16'h0000);
    step(1);
    rst_n = 1'b1;
    issue(16'h0600, 4'd1, 16'h0000, 4'd0, 4'd5);
    pin("post_t1", 1, 16'h0600, 0, 16'h0, 1);
    step(1); pin("post_t2", 0, 16'h0, 0, 16'h0, 0);

    // zero counts never raise busy
    issue(16'h0700, 4'd0, 16'h0700, 4'd0, 4'd3);
    pin("zero_t1", 0, 16'h0, 0, 16'h0, 0);
    step(1);

    for (int i = 0; i < 1500; i++) begin
      op = ($urandom_range(0, 3) == 0);
      first_set = ($urandom_range(0, 40) == 0);
      rd1 = 16'($urandom);
      rd1_st = 16'($urandom);
      func = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      func_st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      dly = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      step(1);
    end
    op = 1'b0; first_set = 1'b0;
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
